// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD pixel streamer: FIFO word layout,
// stream state encoding and the default 800x480 panel timing.
package lcd_pkg;

  localparam int WORD_W  = 32;
  localparam int SOF_BIT = 24;
  localparam int RGB_MSB = 23;
  localparam int RGB_W   = RGB_MSB + 1;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;
  localparam int DEF_H_SYNC   = 48;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BACK   = 32;

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } stream_state_e;

endpackage

// File: rtl/lcd_pixel_streamer_if.sv
// FWFT FIFO read port seen by the streamer: head word, empty flag, pop strobe.
// master = FIFO side, slave = consumer (the streamer).
interface lcd_pixel_streamer_if;
  import lcd_pkg::*;

  logic [WORD_W-1:0] i_fifoData;
  logic              i_fifoEmpty;
  logic              o_fifoRead;

  modport master (
    output i_fifoData,
    output i_fifoEmpty,
    input  o_fifoRead
  );

  modport slave (
    input  i_fifoData,
    input  i_fifoEmpty,
    output o_fifoRead
  );

endinterface

// File: rtl/lcd_timing_gen.sv
// Raster counters for the LCD panel plus the combinational sync, active-area
// and frame-start decodes of the current counter position.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BACK   = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 32
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_active,
  output logic o_frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // One spare value of headroom so the sync-end bound always fits.
  localparam int H_W = $clog2(H_TOTAL + 1);
  localparam int V_W = $clog2(V_TOTAL + 1);

  localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START  = H_W'(H_ACTIVE + H_FRONT);
  localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START  = V_W'(V_ACTIVE + V_FRONT);
  localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [H_W-1:0] h_count_q, h_count_d;
  logic [V_W-1:0] v_count_q, v_count_d;

  // Next raster position: step along the line, advance a line on wrap.
  always_comb begin
    h_count_d = h_count_q + H_W'(1);
    v_count_d = v_count_q;
    if (h_count_q == H_LAST) begin
      h_count_d = '0;
      if (v_count_q == V_LAST) begin
        v_count_d = '0;
      end else begin
        v_count_d = v_count_q + V_W'(1);
      end
    end
  end

  // Counter registers; reset restarts the raster at frame start.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  assign o_active     = (h_count_q < H_ACT_END) && (v_count_q < V_ACT_END);
  assign o_frameStart = (h_count_q == '0) && (v_count_q == '0);
  assign o_hsync      = (h_count_q >= HS_START) && (h_count_q < HS_END);
  assign o_vsync      = (v_count_q >= VS_START) && (v_count_q < VS_END);

endmodule

// File: rtl/lcd_pixel_streamer.sv
// Pops pixel words from a FWFT FIFO, aligns them to the raster using the SOF
// flag, and drives registered RGB/HSYNC/VSYNC/DE to the LCD panel.
module lcd_pixel_streamer
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int H_FRONT          = DEF_H_FRONT,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BACK           = DEF_H_BACK,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int V_FRONT          = DEF_V_FRONT,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BACK           = DEF_V_BACK,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  lcd_pixel_streamer_if.slave  fifo,
  input  logic                 i_clearStatus,
  output logic [RGB_W-1:0]     o_lcdData,
  output logic                 o_lcdHsync,
  output logic                 o_lcdVsync,
  output logic                 o_lcdEnable,
  output logic                 o_locked,
  output logic                 o_underrun,
  output logic                 o_syncError
);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

  logic hsync, vsync, active, frame_start;

  lcd_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_active     (active),
    .o_frameStart (frame_start)
  );

  stream_state_e     state_q, state_d;
  logic [RGB_W-1:0]  lcd_data_q, pixel_d;
  logic              lcd_hsync_q, lcd_vsync_q, lcd_enable_q;
  logic              underrun_q, sync_error_q;
  logic              pop, underrun_set, sync_error_set;

  logic              head_empty, head_sof;
  logic [RGB_W-1:0]  head_rgb;
  logic              unused_word_bits;

  assign head_empty       = fifo.i_fifoEmpty;
  assign head_sof         = fifo.i_fifoData[SOF_BIT];
  assign head_rgb         = fifo.i_fifoData[RGB_MSB:0];
  assign unused_word_bits = ^fifo.i_fifoData[WORD_W-1:SOF_BIT+1];

  // Stream FSM: pick the pop, the pixel to show and the next state.
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    pixel_d        = '0;
    underrun_set   = 1'b0;
    sync_error_set = 1'b0;
    unique case (state_q)
      SEEK: begin
        // Discard stale words until an SOF sits at the head, then wait
        // for the raster to reach frame start before consuming it.
        if (!head_empty) begin
          if (!head_sof) begin
            pop = 1'b1;
          end else if (frame_start) begin
            pop     = 1'b1;
            pixel_d = head_rgb;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (active) begin
          if (head_empty) begin
            underrun_set = 1'b1;
            state_d      = SEEK;
          end else if (head_sof != frame_start) begin
            // SOF must coincide exactly with frame start; leave the word
            // in place so SEEK can realign on it.
            sync_error_set = 1'b1;
            state_d        = SEEK;
          end else begin
            pop     = 1'b1;
            pixel_d = head_rgb;
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // The pop is suppressed during reset so reset leaves the FIFO untouched.
  assign fifo.o_fifoRead = pop && !head_empty && !i_reset;

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= SEEK;
    end else begin
      state_q <= state_d;
    end
  end

  // Panel output registers: one cycle behind the raster counters.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      lcd_data_q   <= '0;
      lcd_enable_q <= 1'b0;
      lcd_hsync_q  <= SYNC_IDLE;
      lcd_vsync_q  <= SYNC_IDLE;
    end else begin
      lcd_data_q   <= pixel_d;
      lcd_enable_q <= active;
      lcd_hsync_q  <= hsync ^ SYNC_IDLE;
      lcd_vsync_q  <= vsync ^ SYNC_IDLE;
    end
  end

  // Sticky status flags; a new event outranks a simultaneous clear.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      underrun_q   <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      underrun_q   <= underrun_set | (underrun_q & ~i_clearStatus);
      sync_error_q <= sync_error_set | (sync_error_q & ~i_clearStatus);
    end
  end

  assign o_lcdData   = lcd_data_q;
  assign o_lcdHsync  = lcd_hsync_q;
  assign o_lcdVsync  = lcd_vsync_q;
  assign o_lcdEnable = lcd_enable_q;
  assign o_locked    = (state_q == LOCKED);
  assign o_underrun  = underrun_q;
  assign o_syncError = sync_error_q;

endmodule

// File: tb/tb_lcd_pixel_streamer.sv
// Directed bench for lcd_pixel_streamer on a tiny 8x6 raster
// (H 4/1/2/1, V 3/1/1/1, syncs active-high) fed by a behavioural FWFT FIFO.
module tb_lcd_pixel_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        hold;
  logic        fifo_clear;
  logic [23:0] o_lcdData;
  logic        o_lcdHsync, o_lcdVsync, o_lcdEnable;
  logic        o_locked, o_underrun, o_syncError;

  int checks = 0;
  int errors = 0;

  // Behavioural FWFT FIFO: written by the stimulus, popped by the DUT.
  logic [31:0] mem [0:63];
  int wr_ptr    = 0;
  int rd_ptr    = 0;
  int pop_count = 0;
  int bad_reads = 0;
  int base;

  always #5 clk = ~clk;

  lcd_pixel_streamer_if fif ();

  assign fif.i_fifoEmpty = hold || (rd_ptr == wr_ptr);
  assign fif.i_fifoData  = mem[rd_ptr[5:0]];

  lcd_pixel_streamer #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(1)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .fifo          (fif),
    .i_clearStatus (clear),
    .o_lcdData     (o_lcdData),
    .o_lcdHsync    (o_lcdHsync),
    .o_lcdVsync    (o_lcdVsync),
    .o_lcdEnable   (o_lcdEnable),
    .o_locked      (o_locked),
    .o_underrun    (o_underrun),
    .o_syncError   (o_syncError)
  );

  always @(posedge clk) begin
    if (fif.o_fifoRead && fif.i_fifoEmpty) bad_reads <= bad_reads + 1;
    if (fifo_clear) begin
      rd_ptr <= wr_ptr;
    end else if (fif.o_fifoRead) begin
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic push(input logic sof, input logic [23:0] rgb);
    mem[wr_ptr[5:0]] = {7'd0, sof, rgb};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Panel outputs for raster position pos (h = pos%8, v = pos/8) showing rgb.
  task automatic chk_raster(input string tag, input int pos, input logic [23:0] rgb);
    int h;
    int v;
    logic en, hs, vs;
    h  = pos % 8;
    v  = (pos / 8) % 6;
    en = (h < 4) && (v < 3);
    hs = (h == 5) || (h == 6);
    vs = (v == 4);
    chk($sformatf("%s_p%0d", tag, pos),
        {5'd0, o_lcdData, o_lcdEnable, o_lcdHsync, o_lcdVsync},
        {5'd0, rgb, en, hs, vs});
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {o_lcdData, o_lcdEnable, o_lcdHsync, o_lcdVsync, o_locked,
              o_underrun, o_syncError, fif.o_fifoRead}, 31'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold = 1'b1;
    fifo_clear = 1'b1;
    step(2);
    fifo_clear = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int idx;
    logic [23:0] exp_rgb;
    rst = 1'b1; clear = 1'b0; hold = 1'b1; fifo_clear = 1'b1;
    step(3);
    fifo_clear = 1'b0;
    rst = 1'b0;
    #1;
    chk_idle("reset_state");

    // Timing only, FIFO empty: one 48-cycle frame.
    for (int p = 0; p < 48; p++) begin
      step(1);
      chk_raster("t1", p, 24'd0);
    end
    chk("t1_underrun", {31'd0, o_underrun}, 32'd0);
    chk("t1_locked", {31'd0, o_locked}, 32'd0);

    // 12-word frame released mid-frame; locks at next frame start.
    push(1'b1, 24'h1);
    for (int k = 2; k <= 12; k++) push(1'b0, 24'(k));
    step(10);
    hold = 1'b0;
    #1;
    chk("t2_hold_sof", {31'd0, fif.o_fifoRead}, 32'd0);
    base = pop_count;
    step(38);
    chk("t2_lock_pop", {31'd0, fif.o_fifoRead}, 32'd1);
    for (int p = 0; p < 24; p++) begin
      step(1);
      idx = (p / 8) * 4 + (p % 8);
      exp_rgb = ((p % 8) < 4) ? 24'(idx + 1) : 24'd0;
      chk_raster("t2", p, exp_rgb);
    end
    chk("t2_pops", pop_count - base, 32'd12);
    chk("t2_locked", {31'd0, o_locked}, 32'd1);
    chk("t2_flags", {30'd0, o_underrun, o_syncError}, 32'd0);

    // Three stale words flushed in SEEK, then an SOF frame.
    do_reset();
    push(1'b0, 24'hAA); push(1'b0, 24'hBB); push(1'b0, 24'hCC);
    push(1'b1, 24'h21);
    for (int k = 1; k < 12; k++) push(1'b0, 24'(32'h21 + k));
    step(2);
    base = pop_count;
    hold = 1'b0;
    #1;
    chk("t3_flush0", {31'd0, fif.o_fifoRead}, 32'd1);
    step(1);
    chk("t3_flush1", {31'd0, fif.o_fifoRead}, 32'd1);
    step(1);
    chk("t3_flush2", {31'd0, fif.o_fifoRead}, 32'd1);
    step(1);
    chk("t3_hold_sof", {31'd0, fif.o_fifoRead}, 32'd0);
    chk("t3_flush_count", pop_count - base, 32'd3);
    step(43);
    chk("t3_lock_pop", {31'd0, fif.o_fifoRead}, 32'd1);
    for (int p = 0; p < 24; p++) begin
      step(1);
      idx = (p / 8) * 4 + (p % 8);
      exp_rgb = ((p % 8) < 4) ? 24'(32'h21 + idx) : 24'd0;
      chk_raster("t3", p, exp_rgb);
    end
    chk("t3_locked", {31'd0, o_locked}, 32'd1);

    // Underrun at pixel 7, relock on the next SOF frame.
    do_reset();
    push(1'b1, 24'h31);
    for (int k = 1; k < 7; k++) push(1'b0, 24'(32'h31 + k));
    hold = 1'b0;
    #1;
    chk("t4_lock_pop", {31'd0, fif.o_fifoRead}, 32'd1);
    for (int p = 0; p < 12; p++) begin
      step(1);
      idx = (p / 8) * 4 + (p % 8);
      exp_rgb = (((p % 8) < 4) && (idx < 7)) ? 24'(32'h31 + idx) : 24'd0;
      chk_raster("t4", p, exp_rgb);
    end
    chk("t4_underrun", {31'd0, o_underrun}, 32'd1);
    chk("t4_unlocked", {31'd0, o_locked}, 32'd0);
    push(1'b1, 24'h41);
    for (int k = 1; k < 12; k++) push(1'b0, 24'(32'h41 + k));
    step(36);
    chk("t4_relock_pop", {31'd0, fif.o_fifoRead}, 32'd1);
    step(1);
    chk_raster("t4_relock", 0, 24'h41);
    chk("t4_relocked", {31'd0, o_locked}, 32'd1);
    chk("t4_underrun_sticky", {31'd0, o_underrun}, 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t4_underrun_cleared", {31'd0, o_underrun}, 32'd0);
    chk_raster("t4_after_clear", 1, 24'h42);

    // Misplaced SOF at pixel 5; clear in the same cycle must lose.
    do_reset();
    push(1'b1, 24'h51);
    for (int k = 1; k < 5; k++) push(1'b0, 24'(32'h51 + k));
    push(1'b1, 24'h66);
    push(1'b0, 24'h67); push(1'b0, 24'h68); push(1'b0, 24'h69);
    hold = 1'b0;
    for (int p = 0; p < 9; p++) begin
      step(1);
      idx = (p / 8) * 4 + (p % 8);
      exp_rgb = ((p % 8) < 4) ? 24'(32'h51 + idx) : 24'd0;
      chk_raster("t5", p, exp_rgb);
    end
    chk("t5_no_pop_sof", {31'd0, fif.o_fifoRead}, 32'd0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk_raster("t5_black", 9, 24'd0);
    chk("t5_syncerr_set_wins", {31'd0, o_syncError}, 32'd1);
    chk("t5_unlocked", {31'd0, o_locked}, 32'd0);
    chk("t5_no_underrun", {31'd0, o_underrun}, 32'd0);
    step(38);
    chk("t5_relock_pop", {31'd0, fif.o_fifoRead}, 32'd1);
    step(1);
    chk_raster("t5_relock", 0, 24'h66);
    chk("t5_relocked", {31'd0, o_locked}, 32'd1);
    chk("t5_syncerr_sticky", {31'd0, o_syncError}, 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t5_syncerr_cleared", {31'd0, o_syncError}, 32'd0);
    chk_raster("t5_after_clear", 1, 24'h67);

    // Reset mid-line while locked with words still queued.
    rst = 1'b1;
    #1;
    chk("t6_read_in_reset", {31'd0, fif.o_fifoRead}, 32'd0);
    base = pop_count;
    step(1);
    chk_idle("t6_reset_outputs");
    chk("t6_no_pop_reset", pop_count - base, 32'd0);
    rst = 1'b0;
    step(1);
    chk_raster("t6_restart", 0, 24'd0);
    step(5);
    chk_raster("t6_restart", 5, 24'd0);
    chk("t6_flush_after_reset", pop_count - base, 32'd2);

    chk("no_read_when_empty", bad_reads, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_streamer.md
Name: lcd_pixel_streamer

Overview:
- Downstream consumer of the HDMI ingester's pixel FIFO.
- Pops 32-bit pixel words from a first-word-fall-through FIFO in the LCD pixel-clock domain.
- Generates the LCD raster timing and drives registered RGB, HSYNC, VSYNC and DE to the panel.
- Aligns FIFO content to the raster using a start-of-frame flag in each word, and recovers from underrun or misalignment.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch in pixels
- H_SYNC, 48, HSYNC width in pixels
- H_BACK, 88, horizontal back porch in pixels
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 13, vertical front porch in lines
- V_SYNC, 3, VSYNC width in lines
- V_BACK, 32, vertical back porch in lines
- SYNC_ACTIVE_HIGH, 0, 1 = syncs active-high; 0 = active-low

Ports:
- i_clock  in  1  pixel clock; sole clock
- i_reset  in  1  synchronous, active-high reset
- i_fifoData  in  32  FWFT head word: [23:0] = RGB {R[23:16],G[15:8],B[7:0]}; [24] = SOF (first pixel of frame); [31:25] ignored
- i_fifoEmpty  in  1  FIFO empty; head invalid when high
- o_fifoRead  out  1  pop strobe; combinational; never high while i_fifoEmpty
- i_clearStatus  in  1  clears sticky flags
- o_lcdData  out  24  registered RGB
- o_lcdHsync  out  1  registered HSYNC
- o_lcdVsync  out  1  registered VSYNC
- o_lcdEnable  out  1  registered DE
- o_locked  out  1  high in LOCKED state
- o_underrun  out  1  sticky: active pixel with FIFO empty while LOCKED
- o_syncError  out  1  sticky: SOF flag where not expected, or missing where expected, while LOCKED

Behaviour:
- Counters:
  - hCount runs 0..H_TOTAL-1 (H_TOTAL = sum of H_* parameters); vCount runs 0..V_TOTAL-1 and increments when hCount wraps.
  - Active region: hCount < H_ACTIVE and vCount < V_ACTIVE.
  - Frame start: hCount = 0 and vCount = 0.
- Sync windows:
  - HSYNC asserted for H_ACTIVE+H_FRONT <= hCount < H_ACTIVE+H_FRONT+H_SYNC.
  - VSYNC asserted for whole lines V_ACTIVE+V_FRONT <= vCount < V_ACTIVE+V_FRONT+V_SYNC.
  - Asserted level = SYNC_ACTIVE_HIGH.
- Output latency: all panel outputs registered; they reflect the counter values of the previous cycle (1 cycle).
- Reset values: counters 0, state SEEK. o_lcdData = 0, o_lcdEnable = 0, syncs at inactive level, o_locked = 0, o_underrun = 0, o_syncError = 0. Reset mid-frame restarts the raster at frame start, drops lock, and leaves FIFO contents untouched.
- State SEEK:
  - Head non-empty with SOF = 0: pop every cycle (flush), in any raster position.
  - Head has SOF = 1: hold (no pop).
  - At frame start with SOF at head: pop, output that pixel, go to LOCKED.
  - In active region, output black (0) with DE still high.
- State LOCKED, active pixel:
  - Empty FIFO: output black, set o_underrun, go to SEEK.
  - Frame start but head SOF = 0: no pop, black, set o_syncError, go to SEEK.
  - Not frame start but head SOF = 1: no pop, black, set o_syncError, go to SEEK.
  - Otherwise: pop and output head RGB.
  - Blanking cycles never pop.
- Sticky flags:
  - i_clearStatus clears o_underrun and o_syncError.
  - A set event in the same cycle as i_clearStatus wins (flag ends at 1).
- FIFO interface: o_fifoRead = 0 whenever i_fifoEmpty = 1, unconditionally.

Decomposition:
- Package lcd_pkg holds:
  - word field constants SOF_BIT = 24, RGB_MSB = 23
  - state enum {SEEK, LOCKED}
  - default timing constants
- Sub-module lcd_timing_gen owns:
  - inputs: i_clock, i_reset
  - counters, and the combinational hsync, vsync, active and frameStart signals
  - the same 8 timing parameters
- The top level holds the FIFO state machine and the output registers.

Test Plan:
Test configuration: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), SYNC_ACTIVE_HIGH = 1.
- Timing only, FIFO always empty:
  - One frame = 48 cycles.
  - o_lcdEnable high 4 cycles per line on lines 0-2.
  - o_lcdHsync high at hCount 5-6 (seen 1 cycle later).
  - o_lcdVsync high for all 8 cycles of line 4.
  - o_lcdData = 0 throughout.
  - o_underrun stays 0 (never locked).
- Preload 12 words, first with SOF, RGB = 0x000001..0x00000C, released mid-frame:
  - Lock at next frame start.
  - o_lcdData = 1..12 in raster order.
  - Exactly 12 pops.
  - o_locked = 1.
- Preload 3 non-SOF words then an SOF frame:
  - The 3 words are popped in consecutive cycles in SEEK.
  - The frame then displays correctly at the next frame start.
- Locked, FIFO runs empty at pixel 7:
  - Pixel 7 = 0, o_underrun = 1, o_locked = 0.
  - The next SOF frame relocks; o_underrun stays 1 until i_clearStatus.
- Locked, SOF injected at pixel 5:
  - No pop, black pixel, o_syncError = 1, state goes to SEEK.
  - Relock occurs at next frame start.
- i_reset asserted mid-line with FIFO non-empty:
  - Next cycle: all outputs at reset values, o_fifoRead = 0.
  - Raster restarts at hCount = 0, vCount = 0.
